// File: rtl/led_pattern_2ch_if.sv
// led_pattern_2ch_if -- CPU-side controls and PWM-side duty codes for the
// two-channel LED pattern generator.
//   ch1_mode / ch2_mode   : 0=off, 1=on, 2=blink, 3=breathe
//   ch1_level / ch2_level : brightness 0..15 (values above 10 clamp to 10)
//   ch1_duty / ch2_duty   : registered duty code 0..10 for the PWM stage
// master : drives the modes and levels and observes the duties (CPU / bench)
// slave  : the pattern generator itself
interface led_pattern_2ch_if;
   logic [1:0] ch1_mode;
   logic [3:0] ch1_level;
   logic [1:0] ch2_mode;
   logic [3:0] ch2_level;
   logic [3:0] ch1_duty;
   logic [3:0] ch2_duty;

   modport master (
      output ch1_mode, ch1_level, ch2_mode, ch2_level,
      input  ch1_duty, ch2_duty
   );

   modport slave (
      input  ch1_mode, ch1_level, ch2_mode, ch2_level,
      output ch1_duty, ch2_duty
   );
endinterface

// File: rtl/led_pattern_2ch.sv
// led_pattern_2ch -- two-channel LED pattern generator.
// A shared prescaler produces a one-cycle tick every TICK_DIV clocks; each
// channel turns its mode/level into a duty code (off, steady, blink, breathe).
// Ports:
//   clk   : system clock
//   reset : synchronous reset, active high
//   bus   : led_pattern_2ch_if.slave (modes/levels in, duties out)

// One pattern channel. All state and the duty output are registered.
module led_pattern_ch #(
   parameter int BLINK_TICKS = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic [1:0] mode,
   input  logic [3:0] level,
   output logic [3:0] duty
);
   localparam int PW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   typedef enum logic [1:0] {M_OFF, M_ON, M_BLINK, M_BREATHE} mode_e;

   mode_e         mode_q;
   logic [PW-1:0] phase, phase_n;
   logic          blink_on, blink_on_n;
   logic [3:0]    value, value_n;
   logic          dir_up, dir_up_n;
   logic [3:0]    lvl;

   always_comb begin
      lvl        = (level > 4'd10) ? 4'd10 : level;
      phase_n    = phase;
      blink_on_n = blink_on;
      value_n    = value;
      dir_up_n   = dir_up;
      if (tick) begin
         if (phase == PW'(BLINK_TICKS - 1)) begin
            phase_n    = '0;
            blink_on_n = ~blink_on;
         end else begin
            phase_n = phase + PW'(1);
         end
         if (dir_up) begin
            if (value >= lvl) begin
               dir_up_n = 1'b0;
               value_n  = (lvl == 4'd0) ? 4'd0 : lvl - 4'd1;
            end else begin
               value_n = value + 4'd1;
            end
         end else begin
            if (value == 4'd0) begin
               dir_up_n = 1'b1;
               value_n  = (lvl == 4'd0) ? 4'd0 : 4'd1;
            end else begin
               value_n = value - 4'd1;
            end
         end
      end
      // A lowered level pulls the ramp down at once, tick or not.
      if (value_n > lvl) value_n = lvl;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q   <= M_OFF;
         phase    <= '0;
         blink_on <= 1'b1;
         value    <= 4'd0;
         dir_up   <= 1'b1;
         duty     <= 4'd0;
      end else if (mode_e'(mode) != mode_q) begin
         // Mode entry wins over a coincident tick.
         mode_q   <= mode_e'(mode);
         phase    <= '0;
         blink_on <= 1'b1;
         value    <= 4'd0;
         dir_up   <= 1'b1;
         duty     <= (mode_e'(mode) == M_ON || mode_e'(mode) == M_BLINK) ? lvl : 4'd0;
      end else begin
         case (mode_q)
            M_OFF: duty <= 4'd0;
            M_ON:  duty <= lvl;
            M_BLINK: begin
               phase    <= phase_n;
               blink_on <= blink_on_n;
               duty     <= blink_on_n ? lvl : 4'd0;
            end
            default: begin
               value  <= value_n;
               dir_up <= dir_up_n;
               duty   <= value_n;
            end
         endcase
      end
   end
endmodule

module led_pattern_2ch #(
   parameter int TICK_DIV    = 2700000,
   parameter int BLINK_TICKS = 5
) (
   input logic               clk,
   input logic               reset,
   led_pattern_2ch_if.slave  bus
);
   localparam int NUM_CH = 2;
   localparam int CW     = $clog2(TICK_DIV);

   logic [CW-1:0]             presc;
   logic                      tick;
   logic [NUM_CH-1:0][1:0]    mode;
   logic [NUM_CH-1:0][3:0]    level;
   logic [NUM_CH-1:0][3:0]    duty;

   // Free-running; mode changes never touch it.
   always_ff @(posedge clk) begin
      if (reset)      presc <= '0;
      else if (tick)  presc <= '0;
      else            presc <= presc + CW'(1);
   end

   assign tick = (presc == CW'(TICK_DIV - 1));

   assign mode         = {bus.ch2_mode, bus.ch1_mode};
   assign level        = {bus.ch2_level, bus.ch1_level};
   assign bus.ch1_duty = duty[0];
   assign bus.ch2_duty = duty[1];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      led_pattern_ch #(.BLINK_TICKS(BLINK_TICKS)) u_ch (
         .clk   (clk),
         .reset (reset),
         .tick  (tick),
         .mode  (mode[g]),
         .level (level[g]),
         .duty  (duty[g])
      );
   end
endmodule

// File: tb/tb_led_pattern_2ch.sv
module tb_led_pattern_2ch;
   localparam int D  = 4;
   localparam int BT = 2;

   logic clk = 1'b0;
   logic reset;
   led_pattern_2ch_if bus ();

   led_pattern_2ch #(.TICK_DIV(D), .BLINK_TICKS(BT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit armed  = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: blink is derived from ticks elapsed since entry,
   // breathe follows the ramp rules directly.
   typedef struct {
      logic [1:0] mode;
      int         ticks;
      int         bval;
      bit         bup;
      int         duty;
   } mst_t;

   function automatic mst_t m_init();
      mst_t s;
      s.mode = 2'd0; s.ticks = 0; s.bval = 0; s.bup = 1'b1; s.duty = 0;
      return s;
   endfunction

   function automatic mst_t step(input mst_t s, input logic [1:0] mode,
                                 input logic [3:0] level, input bit tick);
      mst_t n;
      int   lvl;
      int   v;
      n   = s;
      lvl = (level > 10) ? 10 : int'(level);
      if (mode != s.mode) begin
         n.mode = mode; n.ticks = 0; n.bval = 0; n.bup = 1'b1;
         n.duty = (mode == 2'd1 || mode == 2'd2) ? lvl : 0;
         return n;
      end
      case (mode)
         2'd0: n.duty = 0;
         2'd1: n.duty = lvl;
         2'd2: begin
            if (tick) n.ticks = (s.ticks + 1) % (2 * BT);
            n.duty = (n.ticks < BT) ? lvl : 0;
         end
         default: begin
            v = s.bval;
            if (tick) begin
               if (s.bup) begin
                  if (v >= lvl) begin n.bup = 1'b0; v = (lvl == 0) ? 0 : lvl - 1; end
                  else v = v + 1;
               end else begin
                  if (v == 0) begin n.bup = 1'b1; v = (lvl == 0) ? 0 : 1; end
                  else v = v - 1;
               end
            end
            if (v > lvl) v = lvl;
            n.bval = v;
            n.duty = v;
         end
      endcase
      return n;
   endfunction

   mst_t m1, m2;
   int   edges;   // non-reset edges since reset, modulo D

   always @(posedge clk) begin
      if (reset) begin
         m1    <= m_init();
         m2    <= m_init();
         edges <= 0;
      end else begin
         m1    <= step(m1, bus.ch1_mode, bus.ch1_level, edges == D - 1);
         m2    <= step(m2, bus.ch2_mode, bus.ch2_level, edges == D - 1);
         edges <= (edges + 1) % D;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("model_ch1", int'(bus.ch1_duty), m1.duty);
         chk("model_ch2", int'(bus.ch2_duty), m2.duty);
         chk("range", int'(bus.ch1_duty > 4'd10 || bus.ch2_duty > 4'd10), 0);
      end
   end

   // Ends at the falling edge after the n-th tick edge.
   task automatic wait_ticks(input int n);
      int k = 0;
      while (k < n) begin
         if (edges == D - 1) k++;
         @(negedge clk);
      end
   endtask

   int seq [9] = '{1, 2, 3, 2, 1, 0, 1, 2, 3};

   initial begin
      reset = 1'b1;
      bus.ch1_mode = 2'd1; bus.ch1_level = 4'd7;
      bus.ch2_mode = 2'd0; bus.ch2_level = 4'd0;
      repeat (3) @(negedge clk);
      armed = 1;
      chk("reset_ch1", int'(bus.ch1_duty), 0);
      chk("reset_ch2", int'(bus.ch2_duty), 0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_reset_on", int'(bus.ch1_duty), 7);

      // Clamp and steady
      bus.ch2_mode = 2'd1; bus.ch2_level = 4'd15;
      @(negedge clk);
      chk("clamp15", int'(bus.ch2_duty), 10);
      bus.ch2_level = 4'd3;
      @(negedge clk);
      chk("steady3", int'(bus.ch2_duty), 3);
      bus.ch2_mode = 2'd0;
      @(negedge clk);
      chk("off", int'(bus.ch2_duty), 0);

      // Blink
      bus.ch1_mode = 2'd2; bus.ch1_level = 4'd6;
      @(negedge clk);
      chk("blink_entry", int'(bus.ch1_duty), 6);
      wait_ticks(2);
      chk("blink_off", int'(bus.ch1_duty), 0);
      wait_ticks(2);
      chk("blink_on", int'(bus.ch1_duty), 6);

      // Breathe
      bus.ch1_mode = 2'd3; bus.ch1_level = 4'd3;
      @(negedge clk);
      chk("breathe_entry", int'(bus.ch1_duty), 0);
      for (int i = 0; i < 9; i++) begin
         wait_ticks(1);
         chk($sformatf("breathe_t%0d", i + 1), int'(bus.ch1_duty), seq[i]);
      end
      bus.ch1_level = 4'd1;
      @(negedge clk);
      chk("breathe_lower", int'(bus.ch1_duty), 1);

      // Mode change exactly on a tick edge
      bus.ch1_mode = 2'd2; bus.ch1_level = 4'd5;
      bus.ch2_mode = 2'd2; bus.ch2_level = 4'd4;
      @(negedge clk);
      for (int i = 0; i < D && edges != D - 1; i++) @(negedge clk);
      chk("tick_aligned", int'(edges == D - 1), 1);
      bus.ch1_mode = 2'd3;
      @(negedge clk);
      chk("entry_on_tick", int'(bus.ch1_duty), 0);
      wait_ticks(1);
      chk("after_entry_tick", int'(bus.ch1_duty), 1);

      // Independence: long run at full level
      bus.ch1_level = 4'd10; bus.ch2_level = 4'd10;
      repeat (100 * D) @(negedge clk);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(19) == 0) bus.ch1_mode  = 2'($urandom_range(3));
         if ($urandom_range(19) == 0) bus.ch1_level = 4'($urandom_range(15));
         if ($urandom_range(19) == 0) bus.ch2_mode  = 2'($urandom_range(3));
         if ($urandom_range(19) == 0) bus.ch2_level = 4'($urandom_range(15));
         reset = ($urandom_range(499) == 0);
         @(negedge clk);
      end
      reset = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
